x25519_sub: RTL and testbench

Pipelined field subtractor for the X25519 datapath: the inverse operation to the existing unreduced adder.
- Computes out ≡ a − b (mod p), p = 2^255 − 19, as the non-negative unreduced value a + 8p − b, with no final reduction.
- Same 264-bit operand/result format and en/out_valid handshake as the adder, so the ladder controller can issue add and sub ops interchangeably.
- Full throughput, two-stage carry-split pipeline so the 264-bit carry chain meets timing.

---
 rtl/x25519_pkg.sv | 13 +
 rtl/x25519_carry_stage.sv | 50 +++++
 rtl/x25519_sub.sv | 86 ++++++++
 tb/tb_x25519_sub.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/x25519_pkg.sv
// Shared X25519 field constants and types.
// Used by the adder, subtractor and multiplier datapaths.
package x25519_pkg;

  localparam int FE_W = 264;

  typedef logic [FE_W-1:0] fe_wide_t;

  localparam logic [254:0] P = {255{1'b1}} - 255'd18;

  localparam fe_wide_t EIGHT_P = fe_wide_t'(P) << 3;

endpackage

// File: rtl/x25519_carry_stage.sv
// Registered partial adder: x + y + K + cin -> {cout, sum}.
// Carry is two bits wide since three W-bit terms can exceed 2^(W+1).
module x25519_carry_stage #(
  parameter int           W = 132,
  parameter logic [W-1:0] K = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [1:0]   i_cin,
  output logic         o_valid,
  output logic [W-1:0] o_sum,
  output logic [1:0]   o_cout
);

  logic [W+1:0] w_sum;
  logic         r_valid;
  logic [W-1:0] r_sum;
  logic [1:0]   r_cout;

  assign w_sum = {2'b00, i_x}
               + {2'b00, i_y}
               + {2'b00, K}
               + {{W{1'b0}}, i_cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= '0;
    end else if (i_valid) begin
      r_sum  <= w_sum[W-1:0];
      r_cout <= w_sum[W+1:W];
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;

endmodule

// File: rtl/x25519_sub.sv
// Unreduced field subtractor: out = a + 8p - b over 264 bits.
// Two-stage pipeline split at SPLIT to shorten the carry chain.
module x25519_sub
  import x25519_pkg::*;
#(
  parameter int SPLIT = 132
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  fe_wide_t a,
  input  fe_wide_t b,
  output logic     out_valid,
  output fe_wide_t out
);

  localparam int HW = FE_W - SPLIT;

  localparam logic [SPLIT-1:0] K_LO = EIGHT_P[SPLIT-1:0];
  localparam logic [HW-1:0]    K_HI = EIGHT_P[FE_W-1:SPLIT];

  fe_wide_t         w_nb;
  logic             w_v1;
  logic [SPLIT-1:0] w_lo;
  logic [1:0]       w_c1;
  logic [HW-1:0]    w_hi;
  logic [1:0]       w_unused_c2;

  logic [HW-1:0]    r_a_hi;
  logic [HW-1:0]    r_nb_hi;
  logic [SPLIT-1:0] r_lo2;

  assign w_nb = ~b;

  // Low half: the +1 of the two's complement enters as carry-in.
  x25519_carry_stage #(
    .W (SPLIT),
    .K (K_LO)
  ) u_lo (
    .clk     (clk),
    .rst     (rst),
    .i_valid (en),
    .i_x     (a[SPLIT-1:0]),
    .i_y     (w_nb[SPLIT-1:0]),
    .i_cin   (2'd1),
    .o_valid (w_v1),
    .o_sum   (w_lo),
    .o_cout  (w_c1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_hi  <= '0;
      r_nb_hi <= '0;
    end else if (en) begin
      r_a_hi  <= a[FE_W-1:SPLIT];
      r_nb_hi <= w_nb[FE_W-1:SPLIT];
    end
  end

  x25519_carry_stage #(
    .W (HW),
    .K (K_HI)
  ) u_hi (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_v1),
    .i_x     (r_a_hi),
    .i_y     (r_nb_hi),
    .i_cin   (w_c1),
    .o_valid (out_valid),
    .o_sum   (w_hi),
    .o_cout  (w_unused_c2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo2 <= '0;
    end else if (w_v1) begin
      r_lo2 <= w_lo;
    end
  end

  assign out = {w_hi, r_lo2};

endmodule

// File: tb/tb_x25519_sub.sv
// Bench for x25519_sub: queue model of a + 8p - b mod 2^264.
// Three SPLIT variants share one stimulus stream.
module tb_x25519_sub;
  import x25519_pkg::*;

  localparam fe_wide_t M8P = (264'd1 << 258) - 264'd152;
  localparam fe_wide_t M257 = (264'd1 << 257) - 264'd1;
  localparam fe_wide_t LIM259 = 264'd1 << 259;
  localparam logic [271:0] P272 = (272'd1 << 255) - 272'd19;

  localparam fe_wide_t L_5M3 =
    264'h03_ffffffffffffffff_ffffffffffffffff_ffffffffffffffff_ffffffffffffff_6a;
  localparam fe_wide_t L_8P =
    264'h03_ffffffffffffffff_ffffffffffffffff_ffffffffffffffff_ffffffffffffff_68;
  localparam fe_wide_t L_0M =
    264'h01_ffffffffffffffff_ffffffffffffffff_ffffffffffffffff_ffffffffffffff_69;

  logic clk;
  logic rst;
  logic en;
  fe_wide_t a_in;
  fe_wide_t b_in;

  logic ov0, ov1, ov2;
  fe_wide_t o0, o1, o2;

  x25519_sub #(.SPLIT(132)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a_in), .b(b_in),
    .out_valid(ov0), .out(o0)
  );

  x25519_sub #(.SPLIT(64)) dut64 (
    .clk(clk), .rst(rst), .en(en), .a(a_in), .b(b_in),
    .out_valid(ov1), .out(o1)
  );

  x25519_sub #(.SPLIT(200)) dut200 (
    .clk(clk), .rst(rst), .en(en), .a(a_in), .b(b_in),
    .out_valid(ov2), .out(o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  function automatic fe_wide_t model_sub(fe_wide_t x, fe_wide_t y);
    return x + M8P - y;
  endfunction

  task automatic chk264(string nm, fe_wide_t act, fe_wide_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  typedef struct {
    longint   due;
    fe_wide_t a;
    fe_wide_t b;
    fe_wide_t r;
    bit       inb;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  longint cyc = 0;
  logic ev = 1'b0;
  fe_wide_t eo = '0;
  bit in_rand = 1'b0;
  int rand_valid = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      ev = 1'b0;
      eo = '0;
    end else begin
      ev = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        cur = q.pop_front();
        ev = 1'b1;
        eo = cur.r;
      end
      if (en) begin
        q.push_back('{cyc + 1, a_in, b_in, model_sub(a_in, b_in),
                      (a_in <= M257) && (b_in <= M257)});
      end
    end
    #1;
    chk1("valid", ov0, ev);
    chk264("out", o0, eo);
    chk1("valid_s64", ov1, ev);
    chk264("out_s64", o1, eo);
    chk1("valid_s200", ov2, ev);
    chk264("out_s200", o2, eo);
    if (in_rand && ov0) rand_valid++;
    if (ev && cur.inb) begin
      n_checks++;
      if (o0 >= 264'd1 && o0 < LIM259) n_pass++;
      else $display("FAIL range: got %h want [1,2^259)", o0);
      n_checks++;
      if (((272'(o0) + 272'(cur.b)) % P272) == (272'(cur.a) % P272)) n_pass++;
      else $display("FAIL modp: got %h want a-b mod p", o0);
    end
  end

  function automatic fe_wide_t rnd257();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
    return t[263:0] & M257;
  endfunction

  task automatic op(input fe_wide_t x, input fe_wide_t y);
    en = 1'b1;
    a_in = x;
    b_in = y;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    a_in = '0;
    b_in = '0;
    idle(3);
    chk1("rst_valid", ov0, 1'b0);
    chk264("rst_out", o0, '0);
    rst = 1'b0;
    idle(1);

    chk264("model_5m3", model_sub(264'd5, 264'd3), L_5M3);
    chk264("model_8p", model_sub('0, '0), L_8P);

    op(264'd5, 264'd3);
    @(negedge clk);
    chk1("v_5m3", ov0, 1'b1);
    chk264("lit_5m3", o0, L_5M3);
    idle(2);
    chk1("v_hold", ov0, 1'b0);
    chk264("hold_5m3", o0, L_5M3);

    op('0, '0);
    op('0, M257);
    chk264("lit_8p", o0, L_8P);
    @(negedge clk);
    chk264("lit_0mmax", o0, L_0M);
    idle(2);

    op(264'd1 << 132, 264'd1);
    @(negedge clk);
    chk264("borrow_s132", o0, L_8P + (264'd1 << 132) - 264'd1);
    chk264("borrow_s64", o1, L_8P + (264'd1 << 132) - 264'd1);
    chk264("borrow_s200", o2, L_8P + (264'd1 << 132) - 264'd1);
    idle(2);

    for (int i = 0; i < 4; i++) op(M257, 264'd12345);
    op(M257, M257);
    op(264'd7, M257);
    op('1, '0);
    op('0, '1);
    idle(3);

    in_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case (i % 50)
        0: op(M257, '0);
        1: op('0, M257);
        default: op(rnd257(), rnd257());
      endcase
    end
    idle(2);
    in_rand = 1'b0;
    n_checks++;
    if (rand_valid == 1000) n_pass++;
    else $display("FAIL rand_count: got %0d want 1000", rand_valid);

    op(264'd100, 264'd1);
    op(264'd200, 264'd2);
    rst = 1'b1;
    #1;
    chk1("midrst_valid", ov0, 1'b0);
    chk264("midrst_out", o0, '0);
    idle(2);
    chk1("midrst_valid2", ov0, 1'b0);
    chk264("midrst_out2", o0, '0);
    rst = 1'b0;
    idle(1);
    op(264'd5, 264'd3);
    chk1("post_rst_early", ov0, 1'b0);
    @(negedge clk);
    chk1("post_rst_v", ov0, 1'b1);
    chk264("post_rst_out", o0, L_5M3);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
